// File: rtl/accum57_stream_pkg.sv
// Shared types and widths for the 57-bit streaming accumulator.
// State encoding is fixed so the DONE/ACCUM decode stays stable across netlists.
package accum57_stream_pkg;

  localparam int ACC_W  = 57;
  localparam int TERM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [ACC_W-1:0] zext_term(
    input logic [TERM_W-1:0] t
  );
    return {{(ACC_W-TERM_W){1'b0}}, t};
  endfunction

endpackage

// File: rtl/accum57_stream_adder.sv
// Unsigned 57+16 adder with carry-out; B is zero-extended onto the
// 57-bit operand and the 58-bit result exposes the carry in bit 57.
module customAdder57_41
  import accum57_stream_pkg::*;
(
  input  logic [ACC_W-1:0]  A,
  input  logic [TERM_W-1:0] B,
  output logic [ACC_W:0]    Sum
);

  assign Sum = {1'b0, A} + {1'b0, zext_term(B)};

endmodule

// File: rtl/accum57_stream.sv
// Batch accumulator: sums num_terms 16-bit terms onto init_acc, tracks a
// sticky carry-out flag, and hands the total downstream via valid/ready.
module accum57_stream
  import accum57_stream_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [ACC_W-1:0]  init_acc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TERM_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic              busy
);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic               ovf;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [ACC_W:0]     sum;

  customAdder57_41 u_add (
    .A   (acc),
    .B   (in_data),
    .Sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    count_nxt = count;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          acc_nxt   = init_acc;
          ovf_nxt   = 1'b0;
          count_nxt = num_terms;
          // empty batch skips straight to presenting init_acc
          state_nxt = (num_terms != '0)
                    ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_nxt   = sum[ACC_W-1:0];
          ovf_nxt   = ovf | sum[ACC_W];
          count_nxt = count - CNT_W'(1);
          if (count == CNT_W'(1))
            state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs decode from state only; result is gated to zero outside DONE
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_sum      = '0;
    out_overflow = 1'b0;
    busy         = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        out_valid    = 1'b1;
        out_sum      = acc;
        out_overflow = ovf;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_accum57_stream.sv
// Scoreboard bench for accum57_stream: stimulus pushes expected totals,
// a negedge monitor pops and compares on every result handshake.
module tb_accum57_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_terms = '0;
  logic [56:0] init_acc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [56:0] out_sum;
  logic        out_overflow;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  logic [57:0] exp_q[$];

  accum57_stream #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_terms    (num_terms),
    .init_acc     (init_acc),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: result scoreboard plus hold-stability under backpressure
  logic        hold_prev = 1'b0;
  logic [56:0] prev_sum;
  logic        prev_ovf;
  logic [57:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev && out_valid) begin
        nvec++;
        if (out_sum !== prev_sum || out_overflow !== prev_ovf) begin
          nerr++;
          $display("FAIL hold_stable: got %0h/%0b expected %0h/%0b",
                   out_sum, out_overflow, prev_sum, prev_ovf);
        end
      end
      if (out_valid && out_ready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_result: got %0h/%0b expected none",
                   out_sum, out_overflow);
        end else begin
          e = exp_q.pop_front();
          if ({out_overflow, out_sum} !== e) begin
            nerr++;
            $display("FAIL result: got sum=%0h ovf=%0b expected sum=%0h ovf=%0b",
                     out_sum, out_overflow, e[56:0], e[57]);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_sum  = out_sum;
      prev_ovf  = out_overflow;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [56:0] ia);
    start = 1'b1;
    num_terms = n;
    init_acc = ia;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, output int waits);
    logic rdy;
    in_valid = 1'b1;
    in_data = d;
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      step();
      if (rdy) break;
      waits++;
      if (waits > 20) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(nm, 64'd1, 64'd0);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int tot;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_ovf", 64'(out_overflow), 64'd0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // basic batch 1+2+3
    exp_q.push_back({1'b0, 57'd6});
    do_start(8'd3, 57'd0);
    send(16'd1, w);
    send(16'd2, w);
    send(16'd3, w);
    chk("t1_valid_latency", 64'(out_valid), 64'd1);
    wait_idle("t1_idle_timeout");

    // wrap: 2^57-16 + 16 carries, then +5 does not
    exp_q.push_back({1'b1, 57'd5});
    do_start(8'd2, 57'h1FF_FFFF_FFFF_FFF0);
    send(16'h0010, w);
    send(16'h0005, w);
    wait_idle("t2_idle_timeout");

    // backpressure on both sides
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 57'd300});
    do_start(8'd2, 57'd0);
    in_valid = 1'b1;
    in_data = 16'd100;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1;
    in_data = 16'd200;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_sum", 64'(out_sum), 64'd300);
      chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
    end
    step();
    out_ready = 1'b1;
    start = 1'b1;
    num_terms = 8'd5;
    step();
    start = 1'b0;
    chk("t3_idle_after_hs", 64'(busy), 64'd0);
    chk("t3_valid_drop", 64'(out_valid), 64'd0);
    step();
    chk("t3_start_ignored", 64'(busy), 64'd0);

    // zero-term batch
    exp_q.push_back({1'b0, 57'd1234});
    do_start(8'd0, 57'd1234);
    chk("t4_valid_next", 64'(out_valid), 64'd1);
    chk("t4_no_in_ready", 64'(in_ready), 64'd0);
    wait_idle("t4_idle_timeout");

    // reset mid-batch with an ignored start
    do_start(8'd4, 57'd0);
    send(16'd7, w);
    send(16'd9, w);
    start = 1'b1;
    num_terms = 8'd1;
    init_acc = 57'd999;
    step();
    start = 1'b0;
    chk("t5_start_ignored_busy", 64'(busy), 64'd1);
    chk("t5_start_ignored_rdy", 64'(in_ready), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_sum", 64'(out_sum), 64'd0);
    chk("t5_rst_ovf", 64'(out_overflow), 64'd0);
    step();
    rst = 1'b0;
    step();
    exp_q.push_back({1'b0, 57'd5});
    do_start(8'd1, 57'd0);
    send(16'd5, w);
    wait_idle("t5_idle_timeout");

    // max-length batch of all-ones terms
    exp_q.push_back({1'b0, 57'd16711425});
    do_start(8'd255, 57'd0);
    tot = 0;
    for (int i = 0; i < 255; i++) begin
      send(16'hFFFF, w);
      tot += w;
    end
    chk("t6_accept_stalls", 64'(tot), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd1);
    wait_idle("t6_idle_timeout");

    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
